// File: rtl/lockstep_lb_check_ctrl.sv
// rtl/lockstep_lb_check_ctrl.sv - reset/settle/run sequencer and load-buffer divergence checker
module lockstep_lb_check_ctrl #(
  parameter int RESET_CYCLES = 2,
  parameter int INIT_CYCLES  = 6,
  parameter int CHECK_CYCLE  = 18,
  parameter int CNT_W        = 5,
  parameter int ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic              lb_valid1,
  input  logic              lb_valid2,
  input  logic [ADDR_W-1:0] lb_addr1,
  input  logic [ADDR_W-1:0] lb_addr2,
  output logic              core_reset,
  output logic              init_window,
  output logic              busy,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic              diverge,
  output logic [CNT_W-1:0]  diverge_cycle,
  output logic [1:0]        diverge_kind,
  output logic              done,
  output logic              pass
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RESET  = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_RUN    = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam logic [CNT_W-1:0] RESET_LAST  = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(RESET_CYCLES + INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CHECK_LAST  = CNT_W'(CHECK_CYCLE);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             core_reset_q, core_reset_d;
  logic             init_window_q, init_window_d;
  logic             busy_q, busy_d;
  logic             diverge_q, diverge_d;
  logic [CNT_W-1:0] div_cycle_q, div_cycle_d;
  logic [1:0]       div_kind_q, div_kind_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  logic ev_valid, ev_addr, ev_any, checking, clear_results;

  always_comb begin
    ev_valid = lb_valid1 ^ lb_valid2;
    ev_addr  = lb_valid1 & lb_valid2 & (lb_addr1 != lb_addr2);
    checking = (state_q == ST_SETTLE) || (state_q == ST_RUN);
    ev_any   = checking & (ev_valid | ev_addr);

    state_d       = state_q;
    cnt_d         = cnt_q;
    diverge_d     = diverge_q;
    div_cycle_d   = div_cycle_q;
    div_kind_d    = div_kind_q;
    pass_d        = pass_q;
    clear_results = 1'b0;

    // Only the first divergence of a run is recorded; valid mismatch outranks address mismatch.
    if (ev_any) begin
      diverge_d = 1'b1;
      if (!diverge_q) begin
        div_cycle_d = cnt_q;
        div_kind_d  = ev_valid ? 2'b01 : 2'b10;
      end
    end

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d       = ST_RESET;
          clear_results = 1'b1;
        end
      end
      ST_RESET, ST_SETTLE, ST_RUN: begin
        if (abort) begin
          state_d       = ST_IDLE;
          cnt_d         = '0;
          clear_results = 1'b1;
        end else if (state_q == ST_RUN && cnt_q == CHECK_LAST) begin
          state_d = ST_DONE;
          pass_d  = !(diverge_q | ev_any);
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (state_q == ST_RESET && cnt_q == RESET_LAST) begin
            state_d = ST_SETTLE;
          end else if (state_q == ST_SETTLE && cnt_q == SETTLE_LAST) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_DONE: begin
        if (start) begin
          state_d       = ST_RESET;
          cnt_d         = '0;
          clear_results = 1'b1;
        end
      end
      default: begin
        state_d       = ST_IDLE;
        cnt_d         = '0;
        clear_results = 1'b1;
      end
    endcase

    if (clear_results) begin
      diverge_d   = 1'b0;
      div_cycle_d = '0;
      div_kind_d  = 2'b00;
      pass_d      = 1'b0;
    end

    core_reset_d  = (state_d == ST_IDLE) || (state_d == ST_RESET);
    init_window_d = (state_d == ST_SETTLE);
    busy_d        = (state_d == ST_RESET) || (state_d == ST_SETTLE) || (state_d == ST_RUN);
    done_d        = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      core_reset_q  <= 1'b1;
      init_window_q <= 1'b0;
      busy_q        <= 1'b0;
      diverge_q     <= 1'b0;
      div_cycle_q   <= '0;
      div_kind_q    <= 2'b00;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      core_reset_q  <= core_reset_d;
      init_window_q <= init_window_d;
      busy_q        <= busy_d;
      diverge_q     <= diverge_d;
      div_cycle_q   <= div_cycle_d;
      div_kind_q    <= div_kind_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
    end
  end

  assign core_reset    = core_reset_q;
  assign init_window   = init_window_q;
  assign busy          = busy_q;
  assign cycle_cnt     = cnt_q;
  assign diverge       = diverge_q;
  assign diverge_cycle = div_cycle_q;
  assign diverge_kind  = div_kind_q;
  assign done          = done_q;
  assign pass          = pass_q;

endmodule

// File: tb/tb_lockstep_lb_check_ctrl.sv
// tb/tb_lockstep_lb_check_ctrl.sv - directed runs with a verdict scoreboard for lockstep_lb_check_ctrl
module tb_lockstep_lb_check_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        lb_valid1 = 1'b1;
  logic        lb_valid2 = 1'b1;
  logic [31:0] lb_addr1 = 32'h0;
  logic [31:0] lb_addr2 = 32'h0;
  logic        core_reset, init_window, busy, diverge, done, pass;
  logic [4:0]  cycle_cnt, diverge_cycle;
  logic [1:0]  diverge_kind;

  int checks = 0;
  int errors = 0;
  int verdicts = 0;

  typedef struct {
    int p;
    int d;
    int c;
    int k;
  } verdict_t;
  verdict_t sb_q[$];

  // Per-run directed vectors: up to two injected events, optional start pulse mid-run,
  // and the hand-derived verdict.
  int ev0_c[7]  = '{5, 10, 12, 1, 18, 2, -1};
  int ev0_k[7]  = '{3, 1, 2, 1, 4, 2, 0};
  int ev1_c[7]  = '{-1, -1, 14, -1, -1, 0, -1};
  int ev1_k[7]  = '{0, 0, 1, 0, 0, 1, 0};
  int st_at[7]  = '{-1, -1, -1, -1, 12, -1, -1};
  int x_pass[7] = '{1, 0, 0, 1, 0, 0, 1};
  int x_div[7]  = '{0, 1, 1, 0, 1, 1, 0};
  int x_cyc[7]  = '{0, 10, 12, 0, 18, 2, 0};
  int x_kind[7] = '{0, 1, 2, 0, 1, 2, 0};

  lockstep_lb_check_ctrl dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .lb_valid1(lb_valid1), .lb_valid2(lb_valid2), .lb_addr1(lb_addr1), .lb_addr2(lb_addr2),
    .core_reset(core_reset), .init_window(init_window), .busy(busy), .cycle_cnt(cycle_cnt),
    .diverge(diverge), .diverge_cycle(diverge_cycle), .diverge_kind(diverge_kind),
    .done(done), .pass(pass)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int k, input int kind);
    lb_valid1 = 1'b1;
    lb_valid2 = 1'b1;
    lb_addr1  = 32'h1000 + k * 4;
    lb_addr2  = 32'h1000 + k * 4;
    case (kind)
      1: lb_valid2 = 1'b0;
      2: begin lb_addr1 = 32'h64; lb_addr2 = 32'h68; end
      3: begin lb_valid1 = 1'b0; lb_valid2 = 1'b0; lb_addr2 = lb_addr1 ^ 32'hff; end
      4: lb_valid1 = 1'b0;
      default: ;
    endcase
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " core_reset"}, core_reset, 1);
    chk({tag, " init_window"}, init_window, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " cycle_cnt"}, cycle_cnt, 0);
    chk({tag, " diverge"}, diverge, 0);
    chk({tag, " diverge_cycle"}, diverge_cycle, 0);
    chk({tag, " diverge_kind"}, diverge_kind, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " pass"}, pass, 0);
  endtask

  task automatic run(input int r);
    int m_div, m_cyc, m_kind, kind, evk;
    verdict_t v;
    v.p = x_pass[r]; v.d = x_div[r]; v.c = x_cyc[r]; v.k = x_kind[r];
    sb_q.push_back(v);
    m_div = 0; m_cyc = 0; m_kind = 0;
    set_in(0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k <= 18; k++) begin
      chk($sformatf("r%0d c%0d cycle_cnt", r, k), cycle_cnt, k);
      chk($sformatf("r%0d c%0d core_reset", r, k), core_reset, (k < 2) ? 1 : 0);
      chk($sformatf("r%0d c%0d init_window", r, k), init_window, (k >= 2 && k <= 7) ? 1 : 0);
      chk($sformatf("r%0d c%0d busy", r, k), busy, 1);
      chk($sformatf("r%0d c%0d done", r, k), done, 0);
      chk($sformatf("r%0d c%0d diverge", r, k), diverge, m_div);
      chk($sformatf("r%0d c%0d diverge_cycle", r, k), diverge_cycle, m_cyc);
      chk($sformatf("r%0d c%0d diverge_kind", r, k), diverge_kind, m_kind);
      if (k == 0) chk($sformatf("r%0d pass cleared", r), pass, 0);
      kind = (k == ev0_c[r]) ? ev0_k[r] : (k == ev1_c[r]) ? ev1_k[r] : 0;
      set_in(k, kind);
      start = (k == st_at[r]);
      evk = (kind == 1 || kind == 4) ? 1 : (kind == 2) ? 2 : 0;
      if (k >= 2 && evk != 0) begin
        if (m_div == 0) begin m_cyc = k; m_kind = evk; end
        m_div = 1;
      end
      tick();
    end
    start = 1'b0;
    chk($sformatf("r%0d done", r), done, 1);
    chk($sformatf("r%0d done busy", r), busy, 0);
    chk($sformatf("r%0d done core_reset", r), core_reset, 0);
    chk($sformatf("r%0d done cycle_cnt", r), cycle_cnt, 18);
    set_in(19, 1);
    tick();
    chk($sformatf("r%0d hold done", r), done, 1);
    chk($sformatf("r%0d hold cycle_cnt", r), cycle_cnt, 18);
    chk($sformatf("r%0d hold diverge", r), diverge, m_div);
    chk($sformatf("r%0d hold diverge_cycle", r), diverge_cycle, m_cyc);
    set_in(0, 0);
  endtask

  initial begin : monitor
    logic done_prev;
    verdict_t v;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done === 1'b1 && done_prev !== 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          v = sb_q.pop_front();
          verdicts++;
          chk($sformatf("v%0d pass", verdicts), pass, v.p);
          chk($sformatf("v%0d diverge", verdicts), diverge, v.d);
          chk($sformatf("v%0d diverge_cycle", verdicts), diverge_cycle, v.c);
          chk($sformatf("v%0d diverge_kind", verdicts), diverge_kind, v.k);
          chk($sformatf("v%0d cycle_cnt", verdicts), cycle_cnt, 18);
        end
      end
      done_prev = done;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    #12;
    chk_reset_vals("reset");
    reset_n = 1'b1;
    tick();
    chk_reset_vals("idle");
    for (int r = 0; r < 7; r++) run(r);

    // abort at cnt 9 with start also raised: abort wins, results cleared
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k <= 9; k++) begin
      if (k == 6) chk("abort pre diverge", diverge, 1);
      set_in(k, (k == 5) ? 1 : 0);
      if (k == 9) begin abort = 1'b1; start = 1'b1; end
      tick();
    end
    abort = 1'b0;
    start = 1'b0;
    chk_reset_vals("abort");
    tick();
    chk("abort stays idle busy", busy, 0);

    // asynchronous reset mid-run
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      set_in(k, (k == 10) ? 2 : 0);
      tick();
    end
    chk("pre async diverge", diverge, 1);
    chk("pre async busy", busy, 1);
    #2 reset_n = 1'b0;
    #1 chk_reset_vals("async");
    tick();
    reset_n = 1'b1;
    tick();
    chk_reset_vals("post async");
    run(6);

    repeat (3) tick();
    chk("verdict count", verdicts, 8);
    chk("scoreboard empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lockstep_lb_check_ctrl.md
# lockstep_lb_check_ctrl

Run controller for the dual-copy Sodor 5-stage security harness. It owns the reset and settle sequence for both core copies and opens a bounded run window. During that window it compares the two copies' load-buffer table ports every cycle and latches the first divergence. At a programmed check cycle it reports pass/fail, replacing the free-running counter and ad-hoc reset logic in the harness top.

## Interface

Parameters:
- RESET_CYCLES, 2, cycles core_reset is held high after start
- INIT_CYCLES, 6, cycles of init_window after reset release (regfile-equalisation window)
- CHECK_CYCLE, 18, cycle_cnt value at which the verdict is taken; must satisfy RESET_CYCLES+INIT_CYCLES ≤ CHECK_CYCLE < 2^CNT_W
- CNT_W, 5, width of cycle counter
- ADDR_W, 32, width of lb_table address

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  begin a run; honoured in IDLE or DONE only
- abort  in  1  cancel a run; honoured in RESET/SETTLE/RUN
- lb_valid1, lb_valid2  in  1  lb_table valid, copy 1 / copy 2
- lb_addr1, lb_addr2  in  ADDR_W  lb_table address, copy 1 / copy 2
- core_reset  out  1  active-high reset to both core copies
- init_window  out  1  high during SETTLE
- busy  out  1  high in RESET, SETTLE, RUN
- cycle_cnt  out  CNT_W  cycles since start (0 = first RESET cycle)
- diverge  out  1  sticky: a divergence has been observed this run
- diverge_cycle  out  CNT_W  cycle_cnt of the first divergence
- diverge_kind  out  2  01 = valid mismatch, 10 = address mismatch, 00 = none
- done  out  1  verdict available (DONE state)
- pass  out  1  valid when done; 1 iff no divergence through CHECK_CYCLE

## Operation

- FSM states: IDLE, RESET, SETTLE, RUN, DONE. Reset state is IDLE.
- IDLE: core_reset=1, cycle_cnt=0. On start → RESET, clearing diverge, diverge_cycle, diverge_kind and pass.
- RESET: core_reset=1. cycle_cnt increments each cycle. At cycle_cnt=RESET_CYCLES-1 → SETTLE.
- SETTLE: core_reset=0, init_window=1. At cycle_cnt=RESET_CYCLES+INIT_CYCLES-1 → RUN.
- RUN: core_reset=0. At cycle_cnt=CHECK_CYCLE → DONE.
- DONE: core_reset=0, counter frozen, results held. start → RESET with results cleared.
- Divergence test, evaluated only in SETTLE and RUN: (lb_valid1 ^ lb_valid2), or (lb_valid1 & lb_valid2 & lb_addr1≠lb_addr2).
  - The valid mismatch has priority for diverge_kind.
  - Only the first event records diverge_cycle and diverge_kind; later events leave them unchanged.
- abort in RESET/SETTLE/RUN → IDLE. Results are cleared and done=0.
- start while busy is ignored. abort has priority over start.
- The counter never wraps within a run. The CHECK_CYCLE bound guarantees this.

## Timing

- All outputs are registered.
- Reset values: core_reset=1; all other outputs 0; cycle_cnt=0.
- Assertion of reset_n=0 forces reset values immediately, from any state, mid-run included.
- start sampled at edge N puts the FSM in RESET with cycle_cnt=0 after edge N.
- Divergence on inputs in cycle k (cycle_cnt=k) shows as diverge=1, diverge_cycle=k after the next edge.
- Inputs in the CHECK_CYCLE cycle are evaluated. done=1 and pass appear the following cycle.
- core_reset falls on the edge entering SETTLE (cycle_cnt=RESET_CYCLES).

## Test plan

- Defaults, start, identical inputs throughout → core_reset high for cnt 0–1; init_window high for cnt 2–7; done=1, pass=1, diverge=0 when cycle_cnt reads 18 and done.
- lb_valid1=1, lb_valid2=0 at cnt 10 → diverge=1 next cycle, diverge_cycle=10, diverge_kind=01; at done, pass=0.
- Both valid, addr 0x64 vs 0x68 at cnt 12, then a valid mismatch at cnt 14 → diverge_cycle=12, diverge_kind=10, retained through done.
- Valid mismatch at cnt 1 (core_reset high), clean afterwards → ignored; pass=1.
- abort at cnt 9 → IDLE next cycle: core_reset=1, busy=0, done=0, diverge=0. Separately, reset_n low during RUN → all outputs at reset values without a clock edge.
- start during RUN is ignored (cycle_cnt continues). start in DONE after a fail → RESET with diverge/pass cleared; a clean run then ends with pass=1.
